// File: rtl/wb_reg_host_bridge.sv
// Wishbone classic slave to register-bus master bridge.
// A strobed Wishbone cycle is captured, replayed as a held reg_cs request
// until the peripheral acknowledges or the programmable timeout expires, and
// then completed with a one-cycle ack or error pulse. All outputs are flops.
module wb_reg_host_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        wbm_clk_i,
  input  logic        wbm_rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [8:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        reg_cs,
  output logic        reg_wr,
  output logic [8:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_be,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack,
  output logic        bus_err_o,
  input  logic        bus_err_clr_i
);

  // A zero timeout still needs a legal (1-bit) counter even though it is unused.
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 32'd0) ? $clog2(TIMEOUT_CYC + 32'd1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYC);
  localparam bit               TO_EN   = (TIMEOUT_CYC != 32'd0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              reg_cs_q, reg_cs_d;
  logic              reg_wr_q, reg_wr_d;
  logic [8:0]        reg_addr_q, reg_addr_d;
  logic [31:0]       reg_wdata_q, reg_wdata_d;
  logic [3:0]        reg_be_q, reg_be_d;
  logic [31:0]       dat_q, dat_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              bus_err_q, bus_err_d;
  // Set once the master has dropped stb during the current access.
  logic              abort_q, abort_d;

  logic [CNT_W-1:0]  cnt_inc_s;
  logic              timeout_hit_s;
  logic              timeout_evt_s;
  logic              respond_ok_s;

  // Next-state, capture and completion logic for the request FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reg_cs_d    = reg_cs_q;
    reg_wr_d    = reg_wr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_be_d    = reg_be_q;
    dat_d       = dat_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    abort_d     = abort_q;

    // Counter value after this REQ cycle; saturates at its maximum.
    if (cnt_q == CNT_MAX) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_ONE;
    end

    // Fires on the edge that closes the TIMEOUT_CYC-th REQ cycle.
    timeout_hit_s = TO_EN && (cnt_inc_s == TO_VAL);
    // Ack has priority over a timeout landing on the same edge.
    timeout_evt_s = (state_q == REQ) && !reg_ack && timeout_hit_s;
    // A master that abandoned the cycle gets no ack/err pulse.
    respond_ok_s  = !abort_q && wbs_stb_i;

    case (state_q)
      IDLE: begin
        if (wbs_stb_i) begin
          state_d     = REQ;
          cnt_d       = '0;
          reg_cs_d    = 1'b1;
          reg_wr_d    = wbs_we_i;
          reg_addr_d  = wbs_adr_i;
          reg_wdata_d = wbs_dat_i;
          reg_be_d    = wbs_sel_i;
          abort_d     = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        cnt_d = cnt_inc_s;
        if (!wbs_stb_i) begin
          abort_d = 1'b1;
        end else begin
          abort_d = abort_q;
        end
        if (reg_ack) begin
          state_d  = RESP;
          reg_cs_d = 1'b0;
          ack_d    = respond_ok_s;
          if (!reg_wr_q) begin
            dat_d = reg_rdata;
          end else begin
            dat_d = dat_q;
          end
        end else if (timeout_hit_s) begin
          state_d  = RESP;
          reg_cs_d = 1'b0;
          dat_d    = ERR_DATA;
          err_d    = respond_ok_s;
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        reg_cs_d = 1'b0;
      end
    endcase

    // Sticky error flag: a new timeout beats a simultaneous clear.
    if (timeout_evt_s) begin
      bus_err_d = 1'b1;
    end else if (bus_err_clr_i) begin
      bus_err_d = 1'b0;
    end else begin
      bus_err_d = bus_err_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
    if (!wbm_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      reg_cs_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= 9'd0;
      reg_wdata_q <= 32'd0;
      reg_be_q    <= 4'd0;
      dat_q       <= 32'd0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      bus_err_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reg_cs_q    <= reg_cs_d;
      reg_wr_q    <= reg_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_be_q    <= reg_be_d;
      dat_q       <= dat_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      bus_err_q   <= bus_err_d;
      abort_q     <= abort_d;
    end
  end

  assign reg_cs    = reg_cs_q;
  assign reg_wr    = reg_wr_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_be    = reg_be_q;
  assign wbs_dat_o = dat_q;
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_wb_reg_host_bridge.sv
// Directed self-checking bench for wb_reg_host_bridge (TIMEOUT_CYC = 255).
module tb_wb_reg_host_bridge;

  logic        clk;
  logic        rst_n;
  logic        stb;
  logic        we;
  logic [8:0]  adr;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic        cs;
  logic        wr;
  logic [8:0]  raddr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        rack;
  logic        bus_err;
  logic        bus_err_clr;

  int checks;
  int errors;

  // Results of the most recent access
  int          cs_cycles;
  logic        seen_ack;
  logic        seen_err;
  logic [31:0] seen_dat;
  logic        cap_wr;
  logic [8:0]  cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic        post_ack;
  logic        post_err;

  wb_reg_host_bridge #(
    .TIMEOUT_CYC(255),
    .ERR_DATA   (32'hDEAD_BEEF)
  ) dut (
    .wbm_clk_i    (clk),
    .wbm_rst_n    (rst_n),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (dat_i),
    .wbs_sel_i    (sel),
    .wbs_dat_o    (dat_o),
    .wbs_ack_o    (ack_o),
    .wbs_err_o    (err_o),
    .reg_cs       (cs),
    .reg_wr       (wr),
    .reg_addr     (raddr),
    .reg_wdata    (wdata),
    .reg_be       (be),
    .reg_rdata    (rdata),
    .reg_ack      (rack),
    .bus_err_o    (bus_err),
    .bus_err_clr_i(bus_err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One Wishbone access. ack_after = REQ cycle in which the peripheral acks
  // (0 = never); drop_at = REQ cycle before whose closing edge stb is dropped
  // (0 = never). Outputs are sampled 1 ns after each rising edge.
  task automatic do_access(input logic w, input logic [8:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int ack_after,
                           input logic [31:0] rd, input int drop_at);
    stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    cs_cycles = 0;
    tick();  // E0: request captured
    cap_wr = wr; cap_addr = raddr; cap_wdata = wdata; cap_be = be;
    for (int i = 0; i < 400; i++) begin
      if (!cs) break;
      cs_cycles++;
      if (cs_cycles == ack_after) begin
        rack = 1'b1; rdata = rd;
      end else begin
        rack = 1'b0; rdata = 32'h0BAD_0BAD;
      end
      if (cs_cycles == drop_at) stb = 1'b0;
      tick();
    end
    check_eq("req_terminated", {31'd0, cs}, 32'd0);
    seen_ack = ack_o; seen_err = err_o; seen_dat = dat_o;
    rack = 1'b0; stb = 1'b0;
    tick();  // back in IDLE
    post_ack = ack_o; post_err = err_o;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; stb = 1'b0; we = 1'b0; adr = 9'd0; dat_i = 32'd0; sel = 4'd0;
    rdata = 32'd0; rack = 1'b0; bus_err_clr = 1'b0;
    #12;
    check_eq("rst_cs", {31'd0, cs}, 32'd0);
    check_eq("rst_dat", dat_o, 32'd0);
    check_eq("rst_ack_err_berr", {29'd0, ack_o, err_o, bus_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Write, ack in first REQ cycle
    do_access(1'b1, 9'h080, 32'h1234_5678, 4'hF, 1, 32'h0, 0);
    check_eq("wr_cs_cycles", cs_cycles, 32'd1);
    check_eq("wr_reg_wr", {31'd0, cap_wr}, 32'd1);
    check_eq("wr_addr", {23'd0, cap_addr}, 32'h080);
    check_eq("wr_wdata", cap_wdata, 32'h1234_5678);
    check_eq("wr_be", {28'd0, cap_be}, 32'hF);
    check_eq("wr_ack", {30'd0, seen_ack, seen_err}, 32'd2);
    check_eq("wr_dat_unchanged", seen_dat, 32'd0);
    check_eq("wr_ack_single", {30'd0, post_ack, post_err}, 32'd0);

    // Read, ack after 5 cycles
    do_access(1'b0, 9'h084, 32'h0, 4'hF, 5, 32'hA5A5_0001, 0);
    check_eq("rd_cs_cycles", cs_cycles, 32'd5);
    check_eq("rd_reg_wr", {31'd0, cap_wr}, 32'd0);
    check_eq("rd_addr", {23'd0, cap_addr}, 32'h084);
    check_eq("rd_ack", {30'd0, seen_ack, seen_err}, 32'd2);
    check_eq("rd_dat", seen_dat, 32'hA5A5_0001);
    check_eq("rd_ack_single", {30'd0, post_ack, post_err}, 32'd0);

    // Write leaves previous read data on wbs_dat_o
    do_access(1'b1, 9'h010, 32'hCAFE_F00D, 4'h3, 2, 32'h0, 0);
    check_eq("wr2_be", {28'd0, cap_be}, 32'h3);
    check_eq("wr2_dat_kept", seen_dat, 32'hA5A5_0001);

    // Read timeout
    do_access(1'b0, 9'h1FC, 32'h0, 4'hF, 0, 32'h0, 0);
    check_eq("to_cs_cycles", cs_cycles, 32'd255);
    check_eq("to_err", {30'd0, seen_ack, seen_err}, 32'd1);
    check_eq("to_dat", seen_dat, 32'hDEAD_BEEF);
    check_eq("to_err_single", {30'd0, post_ack, post_err}, 32'd0);
    repeat (3) tick();
    check_eq("to_berr_held", {31'd0, bus_err}, 32'd1);
    bus_err_clr = 1'b1;
    tick();
    bus_err_clr = 1'b0;
    check_eq("berr_cleared", {31'd0, bus_err}, 32'd0);

    // Ack on exactly the timeout edge
    do_access(1'b0, 9'h0C0, 32'h0, 4'hF, 255, 32'h5A5A_1234, 0);
    check_eq("edge_cs_cycles", cs_cycles, 32'd255);
    check_eq("edge_ack_wins", {30'd0, seen_ack, seen_err}, 32'd2);
    check_eq("edge_dat", seen_dat, 32'h5A5A_1234);
    check_eq("edge_no_berr", {31'd0, bus_err}, 32'd0);

    // Stray reg_ack in IDLE
    rack = 1'b1;
    repeat (3) tick();
    check_eq("stray_no_resp", {29'd0, cs, ack_o, err_o}, 32'd0);
    rack = 1'b0;
    tick();
    check_eq("stray_no_resp2", {29'd0, cs, ack_o, err_o}, 32'd0);

    // stb dropped mid-access: access completes, no ack pulse
    do_access(1'b0, 9'h044, 32'h0, 4'hF, 3, 32'h1111_2222, 2);
    check_eq("drop_cs_cycles", cs_cycles, 32'd3);
    check_eq("drop_no_ack", {30'd0, seen_ack, seen_err}, 32'd0);
    check_eq("drop_post", {30'd0, post_ack, post_err}, 32'd0);

    // Reset during REQ
    stb = 1'b1; we = 1'b1; adr = 9'h055; dat_i = 32'h7777_8888; sel = 4'hC;
    tick();
    tick();
    check_eq("pre_rst_cs", {31'd0, cs}, 32'd1);
    rst_n = 1'b0; stb = 1'b0;
    #1;
    check_eq("mid_rst_cs_wr", {30'd0, cs, wr}, 32'd0);
    check_eq("mid_rst_addr", {23'd0, raddr}, 32'd0);
    check_eq("mid_rst_wdata_be", wdata | {28'd0, be}, 32'd0);
    check_eq("mid_rst_dat", dat_o, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("post_rst_quiet", {28'd0, cs, ack_o, err_o, bus_err}, 32'd0);
    check_eq("post_rst_dat", dat_o, 32'd0);

    // Back-to-back after reset release
    do_access(1'b1, 9'h101, 32'h0F0F_0F0F, 4'h5, 1, 32'h0, 0);
    check_eq("b2b_wr_addr", {23'd0, cap_addr}, 32'h101);
    check_eq("b2b_wr_ack", {30'd0, seen_ack, seen_err}, 32'd2);
    do_access(1'b0, 9'h102, 32'h0, 4'hF, 2, 32'h8765_4321, 0);
    check_eq("b2b_rd_cs_cycles", cs_cycles, 32'd2);
    check_eq("b2b_rd_ack", {30'd0, seen_ack, seen_err}, 32'd2);
    check_eq("b2b_rd_dat", seen_dat, 32'h8765_4321);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
